// File: rtl/mst_chn_sched.sv
// Channel scheduler for the FT601 master-FIFO path: round-robin grant over four
// channels, one bounded burst per grant, with a two-cycle guard between grants.
module mst_chn_sched #(
  parameter int MAXBURST = 256,
  parameter int CNTW     = 9,
  parameter int FILLTO   = 15
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] chnena,
  input  logic       strmode,
  input  logic [3:0] srcrdy,
  input  logic [3:0] dstrdy,
  input  logic [3:0] prefnempt,
  input  logic       wrack,
  output logic       prefena,
  output logic [1:0] prefchn,
  output logic       prefmod,
  output logic       prefreq,
  output logic       busreq,
  output logic       bstdone
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARB,
    S_FILL,
    S_XFER,
    S_GUARD
  } state_e;

  state_e          state_q;
  logic [1:0]      last_q;
  logic [1:0]      prefchn_q;
  logic            prefena_q;
  logic            prefmod_q;
  logic            busreq_q;
  logic            bstdone_q;
  logic            guard_q;
  logic [CNTW-1:0] burst_q;
  logic [CNTW-1:0] burst_d;
  logic [7:0]      fill_q;

  logic [3:0] elig;
  logic       any_elig;
  logic [1:0] winner;
  logic [1:0] cand;
  logic       cur_ena, cur_dst, cur_src, cur_pne;
  logic       burst_end;

  assign elig     = chnena & dstrdy & ({4{strmode}} | srcrdy | prefnempt);
  assign any_elig = |elig;

  // Scan from farthest to nearest so the nearest eligible channel after last_q wins.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    winner = last_q;
    cand   = last_q;
    for (int k = 4; k >= 1; k--) begin
      cand = last_q + 2'(k);
      if (elig[cand]) winner = cand;
    end
  end

  assign cur_ena = chnena[prefchn_q];
  assign cur_dst = dstrdy[prefchn_q];
  assign cur_src = srcrdy[prefchn_q];
  assign cur_pne = prefnempt[prefchn_q];

  // busreq_q is high exactly in XFER, so it gates the strobe without extra decode.
  assign prefreq = busreq_q & wrack & cur_pne;

  assign burst_d   = (prefreq && burst_q != CNTW'(MAXBURST)) ? burst_q + CNTW'(1) : burst_q;
  assign burst_end = (burst_d == CNTW'(MAXBURST)) | ~cur_dst | ~cur_ena |
                     (~cur_pne & ~cur_src & ~prefmod_q);

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // samples the same pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      last_q    <= 2'd3;
      prefchn_q <= 2'd0;
      prefena_q <= 1'b0;
      prefmod_q <= 1'b0;
      busreq_q  <= 1'b0;
      bstdone_q <= 1'b0;
      guard_q   <= 1'b0;
      burst_q   <= '0;
      fill_q    <= '0;
    end else begin
      bstdone_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (any_elig) state_q <= S_ARB;
        end
        S_ARB: begin
          if (any_elig) begin
            prefchn_q <= winner;
            last_q    <= winner;
            prefmod_q <= strmode;
            burst_q   <= '0;
            fill_q    <= '0;
            prefena_q <= 1'b1;
            state_q   <= S_FILL;
          end else begin
            state_q <= S_IDLE;
          end
        end
        S_FILL: begin
          if (cur_pne) begin
            busreq_q <= 1'b1;
            state_q  <= S_XFER;
          end else if (fill_q == 8'(FILLTO - 1)) begin
            prefena_q <= 1'b0;
            bstdone_q <= 1'b1;
            guard_q   <= 1'b0;
            state_q   <= S_GUARD;
          end else begin
            fill_q <= fill_q + 8'd1;
          end
        end
        S_XFER: begin
          burst_q <= burst_d;
          if (burst_end) begin
            prefena_q <= 1'b0;
            busreq_q  <= 1'b0;
            bstdone_q <= 1'b1;
            guard_q   <= 1'b0;
            state_q   <= S_GUARD;
          end
        end
        S_GUARD: begin
          // prefchn_q is held here so the last pre-fetch write lands in its channel.
          if (!guard_q) guard_q <= 1'b1;
          else          state_q <= any_elig ? S_ARB : S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign prefena = prefena_q;
  assign prefchn = prefchn_q;
  assign prefmod = prefmod_q;
  assign busreq  = busreq_q;
  assign bstdone = bstdone_q;

endmodule

// File: tb/tb_mst_chn_sched.sv
// Directed bench for mst_chn_sched: a MAXBURST=4 instance for round-robin and
// burst-length checks, and a default instance for the remaining scenarios.
module tb_mst_chn_sched;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] chnena, srcrdy, dstrdy, prefnempt;
  logic       strmode, wrack;

  logic       prefena, prefmod, prefreq, busreq, bstdone;
  logic [1:0] prefchn;
  logic       prefena_s, prefmod_s, prefreq_s, busreq_s, bstdone_s;
  logic [1:0] prefchn_s;

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  mst_chn_sched u_dut (
    .clk(clk), .rst_n(rst_n), .chnena(chnena), .strmode(strmode), .srcrdy(srcrdy),
    .dstrdy(dstrdy), .prefnempt(prefnempt), .wrack(wrack), .prefena(prefena),
    .prefchn(prefchn), .prefmod(prefmod), .prefreq(prefreq), .busreq(busreq),
    .bstdone(bstdone)
  );

  mst_chn_sched #(.MAXBURST(4), .CNTW(3), .FILLTO(15)) u_small (
    .clk(clk), .rst_n(rst_n), .chnena(chnena), .strmode(strmode), .srcrdy(srcrdy),
    .dstrdy(dstrdy), .prefnempt(prefnempt), .wrack(wrack), .prefena(prefena_s),
    .prefchn(prefchn_s), .prefmod(prefmod_s), .prefreq(prefreq_s), .busreq(busreq_s),
    .bstdone(bstdone_s)
  );

  // Inputs change 1 time unit after the rising edge; outputs are sampled 1 unit later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_inputs(input logic [3:0] ena, input logic [3:0] dst,
                            input logic [3:0] src, input logic [3:0] pne,
                            input logic smode, input logic wack);
    chnena = ena; dstrdy = dst; srcrdy = src; prefnempt = pne;
    strmode = smode; wrack = wack;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    set_inputs(4'hF, 4'hF, 4'hF, 4'hF, 1'b1, 1'b1);
    #1;
    tests_run++;
    if ({prefena, prefchn, prefmod, prefreq, busreq, bstdone} !== 7'd0) begin
      tests_failed++;
      $display("FAIL reset_outputs: got %b expected 0000000",
               {prefena, prefchn, prefmod, prefreq, busreq, bstdone});
    end
    tests_run++;
    if ({prefena_s, prefchn_s, prefmod_s, prefreq_s, busreq_s, bstdone_s} !== 7'd0) begin
      tests_failed++;
      $display("FAIL reset_outputs_small: got %b expected 0000000",
               {prefena_s, prefchn_s, prefmod_s, prefreq_s, busreq_s, bstdone_s});
    end
  endtask

  task automatic test_round_robin();
    int   grants = 0;
    int   bursts = 0;
    int   pulses = 0;
    int   gap    = 0;
    logic prev   = 1'b0;
    set_inputs(4'hF, 4'hF, 4'hF, 4'hF, 1'b1, 1'b1);
    do_reset();
    for (int c = 1; c <= 80 && bursts < 5; c++) begin
      step();
      #1;
      if (prefena_s && !prev) begin
        tests_run++;
        if (grants == 0) begin
          if (c !== 2) begin
            tests_failed++;
            $display("FAIL rr_first_latency: got cycle %0d expected 2", c);
          end
        end else if (gap !== 3) begin
          tests_failed++;
          $display("FAIL rr_gap grant %0d: got %0d expected 3", grants, gap);
        end
        tests_run++;
        if (prefchn_s !== 2'(grants % 4)) begin
          tests_failed++;
          $display("FAIL rr_order grant %0d: got %0d expected %0d", grants, prefchn_s, grants % 4);
        end
        grants++;
        pulses = 0;
      end
      if (!prefena_s) gap++;
      else            gap = 0;
      if (prefreq_s) pulses++;
      if (bstdone_s) begin
        tests_run++;
        if (pulses !== 4) begin
          tests_failed++;
          $display("FAIL rr_burst_len burst %0d: got %0d expected 4", bursts, pulses);
        end
        bursts++;
      end
      prev = prefena_s;
    end
    tests_run++;
    if (bursts !== 5) begin
      tests_failed++;
      $display("FAIL rr_timeout: got %0d bursts expected 5", bursts);
    end
  endtask

  task automatic test_dstrdy_drop();
    int n = 0;
    set_inputs(4'b0100, 4'b0100, 4'b0000, 4'b0100, 1'b1, 1'b1);
    do_reset();
    for (int c = 0; c < 40 && n < 10; c++) begin
      step();
      #1;
      if (prefreq) n++;
    end
    tests_run++;
    if (n !== 10) begin
      tests_failed++;
      $display("FAIL drop_words_before: got %0d expected 10", n);
    end
    step();
    dstrdy = 4'b0000;
    wrack  = 1'b0;
    #1;
    tests_run++;
    if (prefreq !== 1'b0) begin
      tests_failed++;
      $display("FAIL drop_extra_prefreq: got %b expected 0", prefreq);
    end
    step();
    #1;
    tests_run++;
    if ({prefena, busreq, prefchn, bstdone} !== 5'b00101) begin
      tests_failed++;
      $display("FAIL drop_guard1 ena,busreq,chn,done: got %b expected 00101",
               {prefena, busreq, prefchn, bstdone});
    end
    step();
    #1;
    tests_run++;
    if ({prefena, busreq, prefchn, bstdone} !== 5'b00100) begin
      tests_failed++;
      $display("FAIL drop_guard2 ena,busreq,chn,done: got %b expected 00100",
               {prefena, busreq, prefchn, bstdone});
    end
  endtask

  task automatic test_fill_timeout();
    int   fill   = 0;
    int   pulses = 0;
    logic seen   = 1'b0;
    logic stray  = 1'b0;
    set_inputs(4'b0010, 4'b0010, 4'b0010, 4'b0000, 1'b0, 1'b1);
    do_reset();
    for (int c = 0; c < 10 && !seen; c++) begin
      step();
      #1;
      if (prefena) seen = 1'b1;
    end
    tests_run++;
    if (!seen || prefchn !== 2'd1) begin
      tests_failed++;
      $display("FAIL fill_grant: got seen=%b chn=%0d expected seen=1 chn=1", seen, prefchn);
    end
    fill = 1;
    for (int c = 0; c < 40; c++) begin
      step();
      srcrdy = 4'b0000;
      #1;
      if (prefreq) pulses++;
      if (!prefena) break;
      fill++;
    end
    tests_run++;
    if (fill !== 15) begin
      tests_failed++;
      $display("FAIL fill_length: got %0d cycles expected 15", fill);
    end
    tests_run++;
    if (bstdone !== 1'b1) begin
      tests_failed++;
      $display("FAIL fill_bstdone: got %b expected 1", bstdone);
    end
    for (int c = 0; c < 6; c++) begin
      step();
      #1;
      if (prefena || prefreq) stray = 1'b1;
      if (prefreq) pulses++;
    end
    tests_run++;
    if (pulses !== 0) begin
      tests_failed++;
      $display("FAIL fill_prefreq: got %0d pulses expected 0", pulses);
    end
    tests_run++;
    if (stray !== 1'b0) begin
      tests_failed++;
      $display("FAIL fill_idle_after: got activity=%b expected 0", stray);
    end
  endtask

  task automatic test_mode_latch();
    logic seen = 1'b0;
    set_inputs(4'b0001, 4'b0001, 4'b0000, 4'b0001, 1'b1, 1'b1);
    do_reset();
    for (int c = 0; c < 10 && !seen; c++) begin
      step();
      #1;
      if (busreq) seen = 1'b1;
    end
    tests_run++;
    if (!seen || prefmod !== 1'b1) begin
      tests_failed++;
      $display("FAIL mode_initial: got seen=%b mod=%b expected seen=1 mod=1", seen, prefmod);
    end
    step();
    strmode = 1'b0;
    #1;
    step();
    #1;
    step();
    #1;
    tests_run++;
    if (prefmod !== 1'b1 || busreq !== 1'b1) begin
      tests_failed++;
      $display("FAIL mode_midburst: got mod=%b busreq=%b expected 1 1", prefmod, busreq);
    end
    step();
    dstrdy = 4'b0000;
    wrack  = 1'b0;
    #1;
    step();
    dstrdy = 4'b0001;
    wrack  = 1'b1;
    #1;
    tests_run++;
    if (bstdone !== 1'b1 || prefmod !== 1'b1) begin
      tests_failed++;
      $display("FAIL mode_guard: got done=%b mod=%b expected 1 1", bstdone, prefmod);
    end
    step();
    #1;
    step();
    #1;
    tests_run++;
    if (prefena !== 1'b0 || prefmod !== 1'b1) begin
      tests_failed++;
      $display("FAIL mode_arb: got ena=%b mod=%b expected 0 1", prefena, prefmod);
    end
    step();
    #1;
    tests_run++;
    if ({prefena, prefmod, prefchn} !== 4'b1000) begin
      tests_failed++;
      $display("FAIL mode_next_grant ena,mod,chn: got %b expected 1000",
               {prefena, prefmod, prefchn});
    end
  endtask

  task automatic test_reset_midburst();
    logic seen = 1'b0;
    int   lat  = 0;
    set_inputs(4'b1000, 4'b1000, 4'b0000, 4'b1000, 1'b1, 1'b1);
    do_reset();
    for (int c = 0; c < 10 && !seen; c++) begin
      step();
      #1;
      if (busreq) seen = 1'b1;
    end
    tests_run++;
    if (!seen || prefchn !== 2'd3) begin
      tests_failed++;
      $display("FAIL rst_grant3: got seen=%b chn=%0d expected seen=1 chn=3", seen, prefchn);
    end
    step();
    step();
    #2;
    rst_n = 1'b0;
    #1;
    tests_run++;
    if ({prefena, prefchn, prefmod, prefreq, busreq, bstdone} !== 7'd0) begin
      tests_failed++;
      $display("FAIL rst_async_outputs: got %b expected 0000000",
               {prefena, prefchn, prefmod, prefreq, busreq, bstdone});
    end
    set_inputs(4'hF, 4'hF, 4'hF, 4'hF, 1'b1, 1'b1);
    step();
    rst_n = 1'b1;
    seen  = 1'b0;
    for (int c = 1; c <= 10 && !seen; c++) begin
      step();
      #1;
      if (prefena) begin
        seen = 1'b1;
        lat  = c;
      end
    end
    tests_run++;
    if (!seen || lat !== 2 || prefchn !== 2'd0) begin
      tests_failed++;
      $display("FAIL rst_restart: got seen=%b lat=%0d chn=%0d expected 1 2 0", seen, lat, prefchn);
    end
  endtask

  task automatic test_wrack_no_data();
    logic seen = 1'b0;
    logic done = 1'b0;
    int   n    = 0;
    set_inputs(4'b0001, 4'b0001, 4'b0001, 4'b0001, 1'b0, 1'b0);
    do_reset();
    for (int c = 0; c < 10 && !seen; c++) begin
      step();
      #1;
      if (busreq) seen = 1'b1;
    end
    for (int c = 0; c < 2; c++) begin
      step();
      wrack = 1'b1;
      #1;
      if (prefreq) n++;
    end
    tests_run++;
    if (!seen || n !== 2) begin
      tests_failed++;
      $display("FAIL stall_pre_words: got seen=%b n=%0d expected 1 2", seen, n);
    end
    for (int c = 0; c < 3; c++) begin
      step();
      prefnempt = 4'b0000;
      #1;
      tests_run++;
      if (prefreq !== 1'b0 || busreq !== 1'b1) begin
        tests_failed++;
        $display("FAIL stall_cycle %0d: got prefreq=%b busreq=%b expected 0 1", c, prefreq, busreq);
      end
    end
    for (int c = 0; c < 400 && !done; c++) begin
      step();
      prefnempt = 4'b0001;
      #1;
      if (prefreq) n++;
      if (bstdone) done = 1'b1;
    end
    tests_run++;
    if (!done || n !== 256) begin
      tests_failed++;
      $display("FAIL stall_total_words: got done=%b n=%0d expected 1 256", done, n);
    end
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_dstrdy_drop();
    test_fill_timeout();
    test_mode_latch();
    test_reset_midburst();
    test_wrack_no_data();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/mst_chn_sched.md
# mst_chn_sched

Channel scheduler for the FT601 master-FIFO datapath: it owns the pre-fetch buffer's control inputs (`prefena`, `prefchn`, `prefmod`, `prefreq`) and grants the shared pre-fetch/bus path to one of four channels at a time. It picks eligible channels round-robin and runs one bounded burst per grant. It guards channel switches so an in-flight pre-fetch write always lands in the channel that requested it. It sits between the configuration registers, the internal FIFOs' status and the FT601 bus-side write FSM.

## Interface
- `MAXBURST`, default 256: maximum words transferred per grant.
- `CNTW`, default 9: burst counter width; must satisfy 2^CNTW > MAXBURST.
- `FILLTO`, default 15: cycles allowed in FILL before the grant is abandoned (max 255).

Ports:
- `clk`  in  1  single system clock; all logic on rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `chnena`  in  4  per-channel enable from config.
- `strmode`  in  1  1 = streaming generator source, 0 = loop-back from internal FIFO.
- `srcrdy`  in  4  internal FIFO not-empty per channel.
- `dstrdy`  in  4  host-side space available per channel (from bus FSM).
- `prefnempt`  in  4  pre-fetch buffer not-empty per channel.
- `wrack`  in  1  bus FSM accepted one word this cycle.
- `prefena`  out  1  pre-fetch enable.
- `prefchn`  out  2  selected channel; also the bus channel.
- `prefmod`  out  1  pre-fetch mode, latched per grant.
- `prefreq`  out  1  pre-fetch read strobe (one word consumed).
- `busreq`  out  1  request the bus FSM to drive write cycles.
- `bstdone`  out  1  one-cycle pulse at the end of each grant.

## Operation
- Eligible channel i: `chnena[i] & dstrdy[i] & (strmode | srcrdy[i] | prefnempt[i])`.
- Round-robin pointer `last` (2 bits, reset to 3). The search order is last+1, last+2, last+3, last, mod 4. The first eligible channel wins.
- FSM states: IDLE, ARB, FILL, XFER, GUARD.
- IDLE: wait until any channel is eligible, then go to ARB.
- ARB (1 cycle):
  - Load `prefchn` and set `last` to the winner.
  - Latch `prefmod = strmode`.
  - Clear the burst and fill counters.
  - Go to FILL. If no channel is still eligible, return to IDLE.
- FILL:
  - `prefena` = 1.
  - Go to XFER when `prefnempt[prefchn]` = 1.
  - If the fill counter reaches FILLTO first, go to GUARD without any transfer.
- XFER:
  - `prefena` = 1, `busreq` = 1.
  - `prefreq = wrack & prefnempt[prefchn]` (combinational).
  - Burst counter increments on each `prefreq`.
- Burst end: leave XFER for GUARD at the first cycle where any of these holds:
  - burst counter = MAXBURST (including the word counted that cycle);
  - `dstrdy[prefchn]` = 0;
  - `chnena[prefchn]` = 0;
  - `!prefnempt[prefchn] & !srcrdy[prefchn] & !prefmod` (source exhausted).
- GUARD (exactly 2 cycles):
  - `prefena` = 0, `busreq` = 0, `prefreq` = 0.
  - `prefchn` is held so the pre-fetch write registered in the last enabled cycle lands in the correct channel.
  - `bstdone` pulses in the first GUARD cycle.
  - Then go to ARB if any channel is eligible, else IDLE.
- `prefchn` and `prefmod` change only in ARB. `strmode` changes take effect at the next grant.
- Pre-fetch data left in a channel after a grant stays there and is sent at that channel's next grant.

## Timing
- Reset values: `prefena` 0, `prefchn` 0, `prefmod` 0, `prefreq` 0, `busreq` 0, `bstdone` 0; state IDLE; `last` 3.
- `prefena`, `busreq`, `prefchn`, `prefmod` and `bstdone` are registered. `prefreq` is combinational from `wrack`, gated by registered state.
- Latency from eligibility to first `prefena`:
  - cycle 0: eligible in IDLE;
  - cycle 1: ARB;
  - cycle 2: FILL with `prefena` = 1.
- First `prefreq` possible the cycle after `prefnempt` rises.
- Minimum gap between grants: 2 GUARD cycles + 1 ARB cycle = 3 cycles with `prefena` = 0 or unassigned.
- Simultaneous end conditions all give the same GUARD transition; one `bstdone`.
- `wrack` with `prefnempt[prefchn]` = 0: no `prefreq`, no count.
- Reset asserted mid-burst: every output drops to its reset value asynchronously. After release: IDLE, and arbitration restarts at channel 0.
- Burst counter saturates at MAXBURST; it never wraps within a grant.

## Test plan
- Reset then all four channels eligible with `wrack` held 1 and MAXBURST=4 -> grants in order 0,1,2,3,0. Each grant has exactly 4 `prefreq` pulses and one `bstdone`. 3-cycle gaps between grants.
- Only channel 2 eligible, `dstrdy[2]` dropped after 10 words -> exactly 10 `prefreq` pulses, then GUARD. `prefchn` stays 2 through both GUARD cycles with `prefena` = 0.
- Loop-back mode, channel 1 `srcrdy` = 0 and `prefnempt` never rising -> FILL lasts 15 cycles, then GUARD. `bstdone` = 1 with zero `prefreq`, then IDLE.
- Streaming mode, `strmode` toggled to 0 mid-burst -> `prefmod` stays 1 until the next ARB, where it becomes 0.
- `rst_n` pulsed low during XFER on channel 3 -> all outputs 0 immediately. After release, the first grant goes to channel 0 if eligible.
- `wrack` = 1 while `prefnempt[prefchn]` = 0 for 3 cycles inside XFER, with `srcrdy` = 1 -> no `prefreq`, burst counter unchanged, state stays XFER.
